// File: rtl/systolic_gemm_engine.sv
// Output-stationary ROWS x COLS systolic GEMM engine with a programmable inner dimension.
// Operand beats stream in over valid/ready. A job FSM runs LOAD, then FLUSH, then DRAIN.
// Results leave one row of C per handshake.
// Optional feature: define SYSTOLIC_SAT_EN for clamping accumulators with sticky per-PE sat flags.
module systolic_gemm_engine #(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned K_MAX      = 256,
  parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(K_MAX),
  localparam int unsigned KW        = $clog2(K_MAX + 1),
  localparam int unsigned RW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [KW-1:0]             k_len,
  output logic                      busy,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] a_data,
  input  logic [COLS*DATA_WIDTH-1:0] b_data,
  output logic                      c_valid,
  input  logic                      c_ready,
  output logic [COLS*ACC_WIDTH-1:0] c_data,
  output logic [RW-1:0]             c_row,
  output logic                      c_last,
  output logic                      c_sat,
  output logic                      done
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned AW = ACC_WIDTH;
  localparam int unsigned FW = $clog2(ROWS + COLS);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDrain} state_e;

  state_e        state_q;
  logic [KW-1:0] k_q, beat_q;
  logic [FW-1:0] flush_q;
  logic [RW-1:0] row_q;
  logic          busy_q, a_ready_q, c_valid_q, done_q;

  logic beat_fire, job_start;
  assign beat_fire = a_valid && a_ready_q;
  assign job_start = (state_q == StIdle) && start && (k_len != '0);

  // Job sequencing: all handshake/status outputs are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      k_q       <= '0;
      beat_q    <= '0;
      flush_q   <= '0;
      row_q     <= '0;
      busy_q    <= 1'b0;
      a_ready_q <= 1'b0;
      c_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (job_start) begin
            k_q       <= k_len;
            beat_q    <= '0;
            busy_q    <= 1'b1;
            a_ready_q <= 1'b1;
            state_q   <= StLoad;
          end
        end
        StLoad: begin
          if (beat_fire) begin
            beat_q <= beat_q + KW'(1);
            if (beat_q == k_q - KW'(1)) begin
              a_ready_q <= 1'b0;
              flush_q   <= '0;
              state_q   <= StFlush;
            end
          end
        end
        StFlush: begin
          // The last beat needs ROWS+COLS-1 more shifts to reach the far corner PE
          if (flush_q == FW'(ROWS + COLS - 2)) begin
            c_valid_q <= 1'b1;
            row_q     <= '0;
            state_q   <= StDrain;
          end else begin
            flush_q <= flush_q + FW'(1);
          end
        end
        StDrain: begin
          if (c_ready) begin
            if (row_q == RW'(ROWS - 1)) begin
              c_valid_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= StIdle;
            end else begin
              row_q <= row_q + RW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Operand/tag wires entering each PE from the west (A) and north (B)
  logic [ROWS-1:0][COLS-1:0][DW-1:0] a_w, b_w;
  logic [ROWS-1:0][COLS-1:0]         t_w;
  logic [ROWS-1:0][COLS-1:0][AW-1:0] acc_pe;
`ifdef SYSTOLIC_SAT_EN
  logic [ROWS-1:0][COLS-1:0]         sat_pe;
`endif

  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    if (r == 0) begin : g_direct
      assign a_w[r][0] = beat_fire ? a_data[r*DW +: DW] : '0;
      assign t_w[r][0] = beat_fire;
    end else begin : g_delay
      logic [r-1:0][DW-1:0] d_q;
      logic [r-1:0]         v_q;
      // Delay row r by r cycles; cycles without a beat shift in a zero bubble
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          d_q <= '0;
          v_q <= '0;
        end else begin
          d_q[0] <= beat_fire ? a_data[r*DW +: DW] : '0;
          v_q[0] <= beat_fire;
          for (int i = 1; i < r; i++) begin
            d_q[i] <= d_q[i-1];
            v_q[i] <= v_q[i-1];
          end
        end
      end
      assign a_w[r][0] = d_q[r-1];
      assign t_w[r][0] = v_q[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_b_skew
    if (c == 0) begin : g_direct
      assign b_w[0][c] = beat_fire ? b_data[c*DW +: DW] : '0;
    end else begin : g_delay
      logic [c-1:0][DW-1:0] d_q;
      // Delay column c by c cycles
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          d_q <= '0;
        end else begin
          d_q[0] <= beat_fire ? b_data[c*DW +: DW] : '0;
          for (int i = 1; i < c; i++) d_q[i] <= d_q[i-1];
        end
      end
      assign b_w[0][c] = d_q[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      logic signed [2*DW-1:0] prod;
      logic [AW-1:0]          prod_x, acc_q, acc_d;

      assign prod   = $signed(a_w[r][c]) * $signed(b_w[r][c]);
      assign prod_x = AW'(prod);

`ifdef SYSTOLIC_SAT_EN
      logic [AW:0] sum;
      logic        sat_q, sat_d;
      // Add one bit of headroom, clamp on signed overflow and latch the sticky flag
      always_comb begin
        sum   = {acc_q[AW-1], acc_q} + {prod_x[AW-1], prod_x};
        acc_d = sum[AW-1:0];
        sat_d = sat_q;
        if (sum[AW] != sum[AW-1]) begin
          acc_d = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
          sat_d = 1'b1;
        end
      end
      assign sat_pe[r][c] = sat_q;
`else
      assign acc_d = acc_q + prod_x;
`endif

      // Accumulate only tagged operands; a new job wipes the previous result
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_q <= '0;
`ifdef SYSTOLIC_SAT_EN
          sat_q <= 1'b0;
`endif
        end else if (job_start) begin
          acc_q <= '0;
`ifdef SYSTOLIC_SAT_EN
          sat_q <= 1'b0;
`endif
        end else if (t_w[r][c]) begin
          acc_q <= acc_d;
`ifdef SYSTOLIC_SAT_EN
          sat_q <= sat_d;
`endif
        end
      end
      assign acc_pe[r][c] = acc_q;

      if (c < COLS - 1) begin : g_pass_a
        logic [DW-1:0] a_q;
        logic          t_q;
        // Forward the A operand and its valid tag east
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            a_q <= '0;
            t_q <= 1'b0;
          end else begin
            a_q <= a_w[r][c];
            t_q <= t_w[r][c];
          end
        end
        assign a_w[r][c+1] = a_q;
        assign t_w[r][c+1] = t_q;
      end

      if (r < ROWS - 1) begin : g_pass_b
        logic [DW-1:0] b_q;
        // Forward the B operand south
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) b_q <= '0;
          else        b_q <= b_w[r][c];
        end
        assign b_w[r+1][c] = b_q;
      end
    end
  end

  // Present the selected row; accumulators are frozen during DRAIN so this holds under stall
  always_comb begin
    c_data = '0;
    for (int c = 0; c < COLS; c++) c_data[c*AW +: AW] = acc_pe[row_q][c];
  end

`ifdef SYSTOLIC_SAT_EN
  assign c_sat = |sat_pe[row_q];
`else
  assign c_sat = 1'b0;
`endif

  assign busy    = busy_q;
  assign a_ready = a_ready_q;
  assign c_valid = c_valid_q;
  assign c_row   = row_q;
  assign c_last  = c_valid_q && (row_q == RW'(ROWS - 1));
  assign done    = done_q;

endmodule
